// File: rtl/prog_loader_if.sv
// ============================================================================
// Module      : prog_loader_if
// Description : Byte-stream input and memory write port of the program loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // master: stream source and memory; slave: the loader itself
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Framed-stream program loader; writes memory and gates CPU reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] MAGIC   = 8'hA5,
  parameter int         TIMEOUT = 1024
) (
  input  wire logic      clk,
  input  wire logic      rstn,
  prog_loader_if.slave   bus,
  input  wire logic      reload,
  output logic           cpu_rstn,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_RUN  = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [8:0]        r_remain;
  logic [7:0]        r_sum;
  logic [IDLE_W-1:0] r_idle;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_rstn;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_take;
  logic              w_timeout;
  logic [7:0]        w_chk_sum;

  always_comb begin
    w_take    = bus.in_valid & r_in_ready;
    w_chk_sum = r_sum + bus.in_data;
    // r_busy is high exactly in ADDR/LEN/DATA/CHK
    w_timeout = r_busy & ~w_take & (r_idle == IDLE_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_remain    <= '0;
      r_sum       <= '0;
      r_idle      <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rstn  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;

      if (w_take)
        r_idle <= '0;
      else if (r_busy)
        r_idle <= r_idle + IDLE_W'(1);

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_in_ready <= 1'b1;
            if (w_take && bus.in_data == MAGIC) begin
              r_state <= S_ADDR;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
              r_done  <= 1'b0;
            end
          end
          S_ADDR: begin
            if (w_take) begin
              r_ptr   <= ADDR_W'(bus.in_data);
              r_state <= S_LEN;
            end
          end
          S_LEN: begin
            if (w_take) begin
              r_remain <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
              r_sum    <= '0;
              r_state  <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_take) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_ptr;
              r_mem_wdata <= bus.in_data;
              r_ptr       <= r_ptr + ADDR_W'(1);
              r_sum       <= r_sum + bus.in_data;
              r_remain    <= r_remain - 9'd1;
              if (r_remain == 9'd1)
                r_state <= S_CHK;
            end
          end
          S_CHK: begin
            if (w_take) begin
              r_busy <= 1'b0;
              if (w_chk_sum == 8'd0) begin
                r_state    <= S_RUN;
                r_done     <= 1'b1;
                r_cpu_rstn <= 1'b1;
                r_in_ready <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (reload) begin
              r_state    <= S_IDLE;
              r_cpu_rstn <= 1'b0;
              r_done     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign cpu_rstn      = r_cpu_rstn;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader against a frame-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;
  localparam int TO = 40;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic reload = 1'b0;
  logic cpu_rstn, busy, done, err;

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .MAGIC(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .reload(reload),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: position within the frame decides each byte's role
  bit         m_started = 0;
  bit         m_ready, m_we, m_cpu, m_busy, m_done, m_err, m_run, m_in;
  logic [7:0] m_addr, m_wdata, m_base, m_sum;
  int         m_idx, m_len, m_idle;

  initial forever begin
    bit acc;
    @(posedge clk);
    acc = bus.in_valid && m_ready;
    m_started = 1;
    if (!rstn) begin
      {m_ready, m_we, m_cpu, m_busy, m_done, m_err, m_run, m_in} = '0;
      m_addr = 0; m_wdata = 0;
    end else begin
      m_we = 0;
      if (m_run) begin
        if (reload) begin m_run = 0; m_cpu = 0; m_done = 0; end
      end else if (!m_in) begin
        if (acc && bus.in_data == 8'hA5) begin
          m_in = 1; m_idx = 0; m_idle = 0; m_err = 0; m_done = 0;
        end
      end else if (acc) begin
        m_idle = 0;
        if (m_idx == 0) m_base = bus.in_data;
        else if (m_idx == 1) begin
          m_len = (bus.in_data == 0) ? 256 : int'(bus.in_data);
          m_sum = 0;
        end else if (m_idx < m_len + 2) begin
          m_we = 1;
          m_addr = 8'(int'(m_base) + m_idx - 2);
          m_wdata = bus.in_data;
          m_sum = 8'(m_sum + bus.in_data);
        end else begin
          m_in = 0;
          if (8'(m_sum + bus.in_data) == 8'd0) begin
            m_run = 1; m_cpu = 1; m_done = 1;
          end else m_err = 1;
        end
        m_idx++;
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_in = 0; m_err = 1; end
      end
      m_ready = !m_run;
      m_busy = m_in;
    end
  end

  // Per-cycle compare plus a write monitor used by the directed checks
  logic [7:0] dut_mem [256];
  int nwr = 0, cyc = 0, last_we_cyc = -10, rise_cyc = -20;
  logic prev_cpu = 1'b0;

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("in_ready", bus.in_ready, m_ready);
      chk("mem_we", bus.mem_we, m_we);
      if (m_we) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("cpu_rstn", cpu_rstn, m_cpu);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
    end
    if (bus.mem_we === 1'b1) begin
      dut_mem[bus.mem_addr] = bus.mem_wdata;
      nwr++;
      last_we_cyc = cyc;
    end
    if (cpu_rstn === 1'b1 && prev_cpu !== 1'b1) rise_cyc = cyc;
    prev_cpu = cpu_rstn;
    cyc++;
  end

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bit ok;
    int n = 0;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    do begin
      ok = (bus.in_ready === 1'b1);
      @(negedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      miscompares++;
      $display("FAIL handshake: byte %0h never accepted, got in_ready=0 expected 1", b);
    end
  endtask

  task automatic send_q(input bq_t q, input int gapmode, input int upto);
    for (int i = 0; i < upto; i++) begin
      drive_byte(q[i]);
      if (gapmode == 1) idle(1);
      else if (gapmode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  function automatic bq_t mk_frame(input logic [7:0] addr, input int len, input bit good);
    bq_t q;
    logic [7:0] s = 0, b;
    q = {8'hA5, addr, 8'(len)};
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      s = s + b;
    end
    q.push_back(good ? 8'(-s) : 8'(-s) ^ 8'h01);
    return q;
  endfunction

  bq_t hz, hz_bad, wrap, tfr;
  logic [7:0] hz_pl [10];

  initial begin
    hz = {8'hA5, 8'h00, 8'h0A, 8'hC1, 8'h0A, 8'hC0, 8'h32, 8'hC8,
          8'hC8, 8'hC6, 8'hC8, 8'h26, 8'h00, 8'hFF};
    hz_pl = '{8'hC1, 8'h0A, 8'hC0, 8'h32, 8'hC8, 8'hC8, 8'hC6, 8'hC8, 8'h26, 8'h00};
    hz_bad = hz;
    hz_bad[13] = 8'h00;
    // checksum byte chosen so that 11+22+33+CHK = 0 mod 256
    wrap = {8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rstn", cpu_rstn, 0);
    chk("rst_flags", {busy, done, err}, 0);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", bus.in_ready, 1);

    // hazard program, back-to-back
    nwr = 0;
    send_q(hz, 0, hz.size());
    #1;
    chk("hz_done", done, 1);
    chk("hz_cpu_rstn", cpu_rstn, 1);
    chk("hz_nwr", nwr, 10);
    for (int i = 0; i < 10; i++) chk("hz_mem", dut_mem[i], hz_pl[i]);
    chk("hz_rise_delay", rise_cyc - last_we_cyc, 1);
    chk("run_in_ready", bus.in_ready, 0);

    // reload, bad checksum, then recovery
    pulse_reload();
    #1;
    chk("reload_cpu", cpu_rstn, 0);
    chk("reload_ready", bus.in_ready, 1);
    chk("reload_done", done, 0);
    send_q(hz_bad, 0, hz_bad.size());
    #1;
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu", cpu_rstn, 0);
    send_q(hz, 0, hz.size());
    #1;
    chk("good_done", done, 1);
    chk("good_err", err, 0);

    // address wrap
    pulse_reload();
    nwr = 0;
    send_q(wrap, 0, wrap.size());
    #1;
    chk("wrap_nwr", nwr, 3);
    chk("wrap_fe", dut_mem[8'hFE], 8'h11);
    chk("wrap_ff", dut_mem[8'hFF], 8'h22);
    chk("wrap_00", dut_mem[8'h00], 8'h33);
    chk("wrap_done", done, 1);

    // junk then hazard frame with in_valid every other cycle
    pulse_reload();
    nwr = 0;
    for (int i = 0; i < 10; i++) dut_mem[i] = 8'h5A;
    tfr = {8'h00, 8'h13};
    send_q(tfr, 1, 2);
    send_q(hz, 1, hz.size());
    #1;
    chk("tog_nwr", nwr, 10);
    for (int i = 0; i < 10; i++) chk("tog_mem", dut_mem[i], hz_pl[i]);
    chk("tog_done", done, 1);

    // truncated frame times out after exactly TO idle cycles
    pulse_reload();
    tfr = {8'hA5, 8'h00, 8'h05};
    send_q(tfr, 0, 3);
    idle(TO - 1);
    #1;
    chk("to_busy_before", busy, 1);
    chk("to_err_before", err, 0);
    idle(1);
    #1;
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_cpu", cpu_rstn, 0);
    chk("to_ready", bus.in_ready, 1);
    send_q(hz, 0, hz.size());
    #1;
    chk("to_recover", done, 1);

    // reset while the 5th payload byte is offered
    pulse_reload();
    nwr = 0;
    tfr = {8'hA5, 8'h10, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
    send_q(tfr, 0, tfr.size());
    bus.in_data = 8'h05;
    bus.in_valid = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_nwr", nwr, 4);
    chk("mrst_we", bus.mem_we, 0);
    chk("mrst_ready", bus.in_ready, 0);
    chk("mrst_flags", {cpu_rstn, busy, done, err}, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_nwr_after", nwr, 4);
    chk("mrst_ready_after", bus.in_ready, 1);

    // randomized traffic, checked cycle by cycle against the model
    for (int it = 0; it < 60; it++) begin
      int act, len, k;
      act = $urandom_range(0, 9);
      if (act != 1 && m_run) pulse_reload();
      len = ($urandom_range(0, 14) == 0) ? 256 : $urandom_range(1, 16);
      tfr = mk_frame(8'($urandom), len, $urandom_range(0, 3) != 0);
      case (act)
        0: begin
          for (int j = 0; j < 3; j++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            drive_byte(b);
          end
          idle(1);
        end
        1: begin
          pulse_reload();
          idle($urandom_range(0, 2));
        end
        2: begin
          k = $urandom_range(1, tfr.size() - 1);
          send_q(tfr, 2, k);
          idle(TO + 2);
        end
        3: begin
          k = $urandom_range(1, tfr.size() - 1);
          send_q(tfr, 2, k);
          rstn = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rstn = 1'b1;
          idle(1);
        end
        default: begin
          send_q(tfr, 2, tfr.size());
          idle($urandom_range(0, 2));
        end
      endcase
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
